// File: rtl/lift.sv
// NTRU-HRSS Lift, N=701, q=8192: serial S3(m/Phi1) lift into Z_q and (x-1)*b.
// One coefficient per clock: 700 edges summing m, then 701 edges writing b/m_sq.
module lift #(
  parameter int N_TER = 700,
  parameter int LOGQ  = 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [2*N_TER:1]            m,
  output logic [LOGQ*(N_TER+1):1]     b,
  output logic [LOGQ*N_TER:1]         m_sq
);

  localparam int IW = $clog2(N_TER + 1);
  localparam int MW = $clog2(2 * N_TER);
  localparam int BW = $clog2(LOGQ * (N_TER + 1));

  localparam logic [IW-1:0] IDX_MSG = IW'(N_TER - 1);
  localparam logic [IW-1:0] IDX_B   = IW'(N_TER);

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    LIFT
  } state_t;

  state_t                      r_state;
  logic [2*N_TER-1:0]          r_m;
  logic [LOGQ*(N_TER+1)-1:0]   r_b;
  logic [LOGQ*N_TER-1:0]       r_msq;
  logic [1:0]                  r_c;
  logic [1:0]                  r_s;
  logic [LOGQ-1:0]             r_bprev;
  logic [IW-1:0]               r_idx;

  logic [MW-1:0]               w_mpos;
  logic [BW-1:0]               w_bpos;
  logic [1:0]                  w_raw;
  logic [1:0]                  w_code;
  logic [1:0]                  w_mi;
  logic [1:0]                  w_s;
  logic [LOGQ-1:0]             w_bi;
  logic [LOGQ-1:0]             w_lc;
  logic [LOGQ-1:0]             w_msq;

  function automatic logic [1:0] add3(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic [2:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= 3'd3) t = t - 3'd3;
    return t[1:0];
  endfunction

  function automatic logic [1:0] neg3(
    input logic [1:0] x
  );
    logic [1:0] r;
    case (x)
      2'd1:    r = 2'd2;
      2'd2:    r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [LOGQ-1:0] lift3(
    input logic [1:0] x
  );
    logic [LOGQ-1:0] r;
    case (x)
      2'd1:    r = LOGQ'(1);
      2'd2:    r = '1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Coefficient fetch and the per-edge lift arithmetic for index r_idx.
  always_comb begin
    w_mpos = {r_idx, 1'b0};
    w_bpos = BW'(r_idx) * BW'(LOGQ);
    w_raw  = r_m[w_mpos +: 2];
    w_code = (w_raw == 2'd3) ? 2'd0 : w_raw;
    w_mi   = (r_idx < IDX_B) ? w_code : 2'd0;
    w_s    = add3(add3(r_s, w_mi), r_c);
    w_bi   = lift3(neg3(w_s));
    w_lc   = lift3(r_c);
    w_msq  = r_bprev - w_bi - w_lc;
  end

  // Control FSM with the result registers written in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_b     <= '0;
      r_msq   <= '0;
      r_c     <= '0;
      r_s     <= '0;
      r_bprev <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_m     <= m;
            r_b     <= '0;
            r_msq   <= '0;
            r_c     <= '0;
            r_s     <= '0;
            r_bprev <= '0;
            r_idx   <= '0;
            r_state <= SUM;
          end
        end
        SUM: begin
          r_c <= add3(r_c, w_code);
          if (r_idx == IDX_MSG) begin
            r_idx   <= '0;
            r_state <= LIFT;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        LIFT: begin
          r_s                  <= w_s;
          r_bprev              <= w_bi;
          r_b[w_bpos +: LOGQ]  <= w_bi;
          if (r_idx != IDX_B) begin
            r_msq[w_bpos +: LOGQ] <= w_msq;
          end
          if (r_idx == IDX_B) begin
            r_idx   <= '0;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign b    = r_b;
  assign m_sq = r_msq;

endmodule

// File: tb/tb_lift.sv
// Bench for lift: randomized messages checked each cycle against a
// formula-level HRSS lift model with a write-progress timeline.
module tb_lift;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [1400:1]  m;
  logic [9113:1]  b;
  logic [9100:1]  m_sq;

  lift dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .m    (m),
    .b    (b),
    .m_sq (m_sq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Edges since the capture edge; -1 means nothing written since reset.
  int kcnt = -1;
  int mcap [700];
  int fb   [701];
  int fm   [700];

  function automatic int lift3i(int v);
    if (v == 1) return 1;
    if (v == 2) return 8191;
    return 0;
  endfunction

  // Direct evaluation of the lift formulas on the captured message.
  task automatic compute_final();
    int c;
    int pre;
    int s;
    int mi;
    c = 0;
    for (int k = 0; k < 700; k++) c += mcap[k];
    c = c % 3;
    pre = 0;
    for (int i = 0; i <= 700; i++) begin
      mi = (i < 700) ? mcap[i] : 0;
      pre += mi;
      s = (pre + (i + 1) * c) % 3;
      fb[i] = lift3i((3 - s) % 3);
    end
    for (int j = 0; j < 700; j++) begin
      int prev;
      prev = (j == 0) ? 0 : fb[j-1];
      fm[j] = (prev - fb[j] - fb[699]) & 8191;
    end
  endtask

  task automatic check_outputs();
    int bad;
    int g;
    int e;
    int bg;
    int be;
    bad = -1; bg = 0; be = 0;
    for (int i = 0; i <= 700; i++) begin
      e = (kcnt >= 701 + i) ? fb[i] : 0;
      g = int'(b[13*i+13 -: 13]);
      if (g != e && bad < 0) begin
        bad = i; bg = g; be = e;
      end
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL b t=%0t k=%0d coef=%0d got=%0d exp=%0d",
               $time, kcnt, bad, bg, be);
    end
    bad = -1;
    for (int j = 0; j < 700; j++) begin
      e = (kcnt >= 701 + j) ? fm[j] : 0;
      g = int'(m_sq[13*j+13 -: 13]);
      if (g != e && bad < 0) begin
        bad = j; bg = g; be = e;
      end
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL m_sq t=%0t k=%0d coef=%0d got=%0d exp=%0d",
               $time, kcnt, bad, bg, be);
    end
  endtask

  // Model update on each edge, then compare after the DUT has settled.
  always @(posedge clk) begin
    if (rst) begin
      kcnt = -1;
    end else if (kcnt < 0 || kcnt >= 1401) begin
      if (en) begin
        for (int k = 0; k < 700; k++) begin
          int cd;
          cd = int'(m[2*k+2 -: 2]);
          mcap[k] = (cd == 3) ? 0 : cd;
        end
        compute_final();
        kcnt = 0;
      end
    end else begin
      kcnt++;
    end
    #1;
    check_outputs();
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic rand_m();
    for (int k = 0; k < 700; k++) m[2*k+2 -: 2] = 2'($urandom_range(0, 3));
  endtask

  function automatic int msum3();
    int s;
    int cd;
    s = 0;
    for (int k = 0; k < 700; k++) begin
      cd = int'(m[2*k+2 -: 2]);
      if (cd != 3) s += cd;
    end
    return s % 3;
  endfunction

  task automatic run_op();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (1401) @(negedge clk);
  endtask

  function automatic int bc(int i);
    return int'(b[13*i+13 -: 13]);
  endfunction

  function automatic int mc(int j);
    return int'(m_sq[13*j+13 -: 13]);
  endfunction

  initial begin
    int sc;
    rst = 1'b1;
    en  = 1'b0;
    m   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("idle_b0", bc(0), 0);
    chk("idle_b700", bc(700), 0);
    chk("idle_msq0", mc(0), 0);

    run_op();
    chk("zero_b0", bc(0), 0);
    chk("zero_b699", bc(699), 0);
    chk("zero_msq5", mc(5), 0);

    m = '0;
    m[2:1] = 2'd1;
    run_op();
    chk("one_b0", bc(0), 1);
    chk("one_b1", bc(1), 0);
    chk("one_b2", bc(2), 8191);
    chk("one_b699", bc(699), 1);
    chk("one_b700", bc(700), 0);
    chk("one_msq0", mc(0), 8190);
    chk("one_msq1", mc(1), 0);

    for (int r = 0; r < 2; r++) begin
      rand_m();
      sc = msum3();
      run_op();
      chk("rnd_b700", bc(700), 0);
      chk("rnd_b699", bc(699), lift3i(sc));
    end

    rand_m();
    sc = msum3();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (500) @(negedge clk);
    en = 1'b1;
    rand_m();
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (898) @(negedge clk);
    chk("reen_b699", bc(699), lift3i(sc));
    rand_m();
    run_op();

    rand_m();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (800) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_b0", bc(0), 0);
    chk("rst_msq0", mc(0), 0);
    rand_m();
    run_op();

    rand_m();
    en = 1'b1;
    repeat (1452) @(negedge clk);
    en = 1'b0;
    repeat (1401) @(negedge clk);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
